// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM with byte-lane writes and a registered read,
// plus an MMIO window holding a console TX FIFO, a 64-bit cycle timer and TOHOST.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] DMEM_addr_i,
    input  logic [31:0] DMEM_data_i,
    input  logic        DMEM_read_i,
    input  logic [3:0]  DMEM_write_byte_i,
    output logic [31:0] DMEM_data_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [7:0] OFF_CON_TX     = 8'h00;
    localparam logic [7:0] OFF_CON_STATUS = 8'h04;
    localparam logic [7:0] OFF_MTIME_LO   = 8'h08;
    localparam logic [7:0] OFF_MTIME_HI   = 8'h0C;
    localparam logic [7:0] OFF_TOHOST     = 8'h10;

    logic          mmio_sel;
    logic [AW-1:0] ram_idx;
    logic [7:0]    off;
    logic          wr_any;
    logic          unused_addr;

    assign mmio_sel    = (DMEM_addr_i[31:28] == MMIO_BASE[31:28]);
    assign ram_idx     = DMEM_addr_i[AW+1:2];
    assign off         = DMEM_addr_i[7:0];
    assign wr_any      = |DMEM_write_byte_i;
    assign unused_addr = ^DMEM_addr_i;

    // RAM: no reset on storage; a write sampled during reset is discarded.
    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset_n && !mmio_sel) begin
            for (int k = 0; k < 4; k++) begin
                if (DMEM_write_byte_i[k]) begin
                    mem_q[ram_idx][8*k +: 8] <= DMEM_data_i[8*k +: 8];
                end
            end
        end
    end

    logic [31:0] data_q;
    logic [63:0] mtime_q;
    logic [31:0] shadow_q;
    logic [31:0] tohost_q;
    logic        tohost_valid_q;
    logic [7:0]  fifo_q [4];
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  count_q;
    logic [2:0]  count_d;
    logic        ovf_q;
    logic        ovf_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        lo_rd;
    logic        th_wr;
    logic [31:0] mmio_rdata;
    logic [31:0] rdata_d;

    assign fifo_full  = (count_q == 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    assign pop        = !fifo_empty && con_ready_i;
    assign push_req   = mmio_sel && (off == OFF_CON_TX) && DMEM_write_byte_i[0];
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign lo_rd      = mmio_sel && DMEM_read_i && (off == OFF_MTIME_LO);
    assign th_wr      = mmio_sel && (off == OFF_TOHOST) && (DMEM_write_byte_i == 4'b1111);

    always_comb begin
        count_d = count_q + {2'b00, push_ok} - {2'b00, pop};
        ovf_d   = ovf_q;
        if (mmio_sel && (off == OFF_CON_STATUS) && wr_any) begin
            ovf_d = 1'b0;
        end else if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        mmio_rdata = 32'h0;
        case (off)
            OFF_CON_STATUS: mmio_rdata = {29'b0, ovf_q, fifo_full, fifo_empty};
            OFF_MTIME_LO:   mmio_rdata = mtime_q[31:0];
            OFF_MTIME_HI:   mmio_rdata = shadow_q;
            OFF_TOHOST:     mmio_rdata = tohost_q;
            default:        mmio_rdata = 32'h0;
        endcase
    end

    // Combinational RAM read sees the pre-write word, giving read-first behaviour.
    assign rdata_d = mmio_sel ? mmio_rdata : mem_q[ram_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q         <= 32'h0;
            mtime_q        <= 64'h0;
            shadow_q       <= 32'h0;
            tohost_q       <= 32'h0;
            tohost_valid_q <= 1'b0;
            wr_ptr_q       <= 2'd0;
            rd_ptr_q       <= 2'd0;
            count_q        <= 3'd0;
            ovf_q          <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 8'h0;
            end
        end else begin
            if (DMEM_read_i) begin
                data_q <= rdata_d;
            end
            mtime_q <= mtime_q + 64'd1;
            if (lo_rd) begin
                shadow_q <= mtime_q[63:32];
            end
            tohost_valid_q <= th_wr;
            if (th_wr) begin
                tohost_q <= DMEM_data_i;
            end
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= DMEM_data_i[7:0];
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign DMEM_data_o    = data_q;
    assign con_valid_o    = !fifo_empty;
    assign con_data_o     = fifo_q[rd_ptr_q];
    assign tohost_valid_o = tohost_valid_q;
    assign tohost_o       = tohost_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected read data, console bytes
// and TOHOST pulses; a negedge monitor compares whenever the DUT presents each output.
module tb_dmem_responder;

    logic        clk;
    logic        reset_n;
    logic [31:0] DMEM_addr_i;
    logic [31:0] DMEM_data_i;
    logic        DMEM_read_i;
    logic [3:0]  DMEM_write_byte_i;
    logic [31:0] DMEM_data_o;
    logic        con_valid_o;
    logic [7:0]  con_data_o;
    logic        con_ready_i;
    logic        tohost_valid_o;
    logic [31:0] tohost_o;

    dmem_responder #(
        .DEPTH_WORDS(4096),
        .MMIO_BASE  (32'h8000_0000)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .DMEM_addr_i      (DMEM_addr_i),
        .DMEM_data_i      (DMEM_data_i),
        .DMEM_read_i      (DMEM_read_i),
        .DMEM_write_byte_i(DMEM_write_byte_i),
        .DMEM_data_o      (DMEM_data_o),
        .con_valid_o      (con_valid_o),
        .con_data_o       (con_data_o),
        .con_ready_i      (con_ready_i),
        .tohost_valid_o   (tohost_valid_o),
        .tohost_o         (tohost_o)
    );

    localparam logic [31:0] CON_TX     = 32'h8000_0000;
    localparam logic [31:0] CON_STATUS = 32'h8000_0004;
    localparam logic [31:0] MTIME_LO   = 32'h8000_0008;
    localparam logic [31:0] MTIME_HI   = 32'h8000_000C;
    localparam logic [31:0] TOHOST     = 32'h8000_0010;

    int checks;
    int failures;

    logic [31:0] rd_exp  [$];
    logic [7:0]  con_exp [$];
    logic [31:0] th_exp  [$];
    logic        rd_at_edge;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%h expected=none", name, act);
    endtask

    always @(posedge clk) rd_at_edge = DMEM_read_i && reset_n;

    always @(negedge clk) begin
        if (rd_at_edge) begin
            if (rd_exp.size() == 0) unexpected("rd_data", DMEM_data_o);
            else check("rd_data", DMEM_data_o, rd_exp.pop_front());
        end
        if (con_valid_o && con_ready_i) begin
            if (con_exp.size() == 0) unexpected("con_byte", {24'b0, con_data_o});
            else check("con_byte", {24'b0, con_data_o}, {24'b0, con_exp.pop_front()});
        end
        if (tohost_valid_o) begin
            if (th_exp.size() == 0) unexpected("tohost_pulse", tohost_o);
            else check("tohost_pulse", tohost_o, th_exp.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic idle();
        DMEM_read_i       = 1'b0;
        DMEM_write_byte_i = 4'b0000;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        DMEM_addr_i       = a;
        DMEM_data_i       = d;
        DMEM_write_byte_i = be;
        DMEM_read_i       = 1'b0;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        rd_exp.push_back(exp);
        DMEM_addr_i       = a;
        DMEM_read_i       = 1'b1;
        DMEM_write_byte_i = 4'b0000;
        cyc();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        DMEM_addr_i = 32'h0;
        DMEM_data_i = 32'h0;
        con_ready_i = 1'b0;
        idle();
        repeat (3) cyc();
        check("rst_data",         DMEM_data_o,    32'h0);
        check("rst_con_valid",    {31'b0, con_valid_o},    32'h0);
        check("rst_con_data",     {24'b0, con_data_o},     32'h0);
        check("rst_tohost_valid", {31'b0, tohost_valid_o}, 32'h0);
        check("rst_tohost",       tohost_o,       32'h0);
        reset_n = 1'b1;

        // Edges 1..9 idle, MTIME_LO sampled at edge 10.
        repeat (9) cyc();
        rd(MTIME_LO, 32'd9);
        rd(MTIME_HI, 32'd0);

        wr(32'h0000_0100, 32'h1122_3344, 4'b1111);
        wr(32'h0000_0100, 32'h00AA_0000, 4'b0100);
        rd(32'h0000_0100, 32'h11AA_3344);
        rd(32'h0000_4100, 32'h11AA_3344);
        rd(32'h7000_0100, 32'h11AA_3344);

        wr(32'h0000_0200, 32'hDEAD_0000, 4'b1111);
        rd_exp.push_back(32'hDEAD_0000);
        DMEM_addr_i       = 32'h0000_0200;
        DMEM_data_i       = 32'hBEEF_0000;
        DMEM_write_byte_i = 4'b1111;
        DMEM_read_i       = 1'b1;
        cyc();
        idle();
        rd(32'h0000_0200, 32'hBEEF_0000);
        repeat (3) cyc();
        check("rd_hold", DMEM_data_o, 32'hBEEF_0000);

        for (int i = 0; i < 5; i++) begin
            if (i < 4) con_exp.push_back(8'h41 + 8'(i));
            wr(CON_TX, 32'h41 + 32'(i), 4'b0001);
        end
        check("con_head", {24'b0, con_data_o}, 32'h41);
        rd(CON_STATUS, 32'b110);
        con_ready_i = 1'b1;
        repeat (4) cyc();
        rd(CON_STATUS, 32'b101);
        wr(CON_STATUS, 32'h0, 4'b0001);
        rd(CON_STATUS, 32'b001);
        con_ready_i = 1'b0;

        for (int i = 0; i < 4; i++) begin
            con_exp.push_back(8'h50 + 8'(i));
            wr(CON_TX, 32'h50 + 32'(i), 4'b0001);
        end
        rd(CON_STATUS, 32'b010);
        con_exp.push_back(8'h58);
        con_ready_i = 1'b1;
        wr(CON_TX, 32'h58, 4'b0001);
        con_ready_i = 1'b0;
        rd(CON_STATUS, 32'b010);
        con_ready_i = 1'b1;
        repeat (4) cyc();
        rd(CON_STATUS, 32'b001);
        con_ready_i = 1'b0;

        th_exp.push_back(32'h1);
        wr(TOHOST, 32'h1, 4'b1111);
        wr(TOHOST, 32'h0000_0022, 4'b0011);
        rd(TOHOST, 32'h1);
        th_exp.push_back(32'h5);
        th_exp.push_back(32'h7);
        wr(TOHOST, 32'h5, 4'b1111);
        wr(TOHOST, 32'h7, 4'b1111);
        rd(TOHOST, 32'h7);
        rd(32'h8000_0020, 32'h0);
        rd(CON_TX, 32'h0);

        // Reset lands together with a TOHOST write while the FIFO holds a byte.
        wr(CON_TX, 32'h5A, 4'b0001);
        wr(TOHOST, 32'h0000_00EE, 4'b1111);
        th_exp.push_back(32'hEE);
        rd(TOHOST, 32'hEE);
        DMEM_addr_i       = TOHOST;
        DMEM_data_i       = 32'h9;
        DMEM_write_byte_i = 4'b1111;
        reset_n           = 1'b0;
        cyc();
        idle();
        reset_n = 1'b1;
        check("mid_rst_tohost",       tohost_o,                32'h0);
        check("mid_rst_tohost_valid", {31'b0, tohost_valid_o}, 32'h0);
        check("mid_rst_con_valid",    {31'b0, con_valid_o},    32'h0);
        check("mid_rst_con_data",     {24'b0, con_data_o},     32'h0);
        check("mid_rst_data",         DMEM_data_o,             32'h0);
        rd(MTIME_LO, 32'd0);
        rd(MTIME_HI, 32'd0);
        rd(MTIME_LO, 32'd2);
        rd(32'h0000_0100, 32'h11AA_3344);

        repeat (3) cyc();
        check("rd_queue_empty",  32'(rd_exp.size()),  32'd0);
        check("con_queue_empty", 32'(con_exp.size()), 32'd0);
        check("th_queue_empty",  32'(th_exp.size()),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core. It sits on the far side of the DMEM bus driven by the MEM stage and provides a word-organised RAM with per-byte write enables and a one-cycle registered read. It also decodes a small MMIO window containing a console TX FIFO, a free-running 64-bit cycle timer and a TOHOST register that the test environment uses to end a simulation.

## Interface
- DEPTH_WORDS, 4096, RAM depth in 32-bit words; must be a power of two.
- MMIO_BASE, 32'h8000_0000, MMIO window base; only bits [31:28] are decoded.
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- DMEM_addr_i  in  32  byte address.
- DMEM_data_i  in  32  write data, already lane-aligned by the initiator.
- DMEM_read_i  in  1  load request.
- DMEM_write_byte_i  in  4  byte-lane write enables; bit k selects lane [8k+7:8k].
- DMEM_data_o  out  32  registered read data.
- con_valid_o  out  1  console FIFO head is valid.
- con_data_o  out  8  console FIFO head byte.
- con_ready_i  in  1  console sink accepts the head byte.
- tohost_valid_o  out  1  one-cycle pulse when TOHOST is written.
- tohost_o  out  32  last value written to TOHOST.

## Operation
- Address decode: if addr[31:28] == MMIO_BASE[31:28], the access goes to MMIO. Otherwise it goes to RAM.
- RAM index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses alias and wrap. addr[1:0] is ignored.
- RAM write: at each clk edge, every lane with its DMEM_write_byte_i bit set is updated. Other lanes are unchanged.
- RAM read: on an edge with DMEM_read_i=1, DMEM_data_o is loaded with the full word. The responder does no lane extraction.
- When DMEM_read_i=0, DMEM_data_o holds its previous value.
- Read and write to the same address in the same cycle: the read returns the old word (read-first).
- MMIO registers are selected by addr[7:0]. Unmapped offsets read 0 and ignore writes.
  - 0x00 CON_TX: a write with lane 0 enabled pushes data[7:0] into a 4-entry FIFO. If the FIFO is full, the byte is dropped and the sticky overflow flag is set. Reads return 0.
  - 0x04 CON_STATUS: reads return {29'b0, overflow, full, empty}. A write with any lane enabled clears overflow.
  - 0x08 MTIME_LO: reads return mtime[31:0] and also copy mtime[63:32] into a shadow register in the same edge.
  - 0x0C MTIME_HI: reads return the shadow register, which gives tear-free 64-bit reads. MTIME_LO and MTIME_HI ignore writes.
  - 0x10 TOHOST: only a write with DMEM_write_byte_i == 4'b1111 updates tohost_o and pulses tohost_valid_o. Partial writes are ignored. Reads return tohost_o.
- mtime increments by 1 on every edge with reset_n=1 and wraps from 2^64-1 to 0. A read returns the pre-increment value at the sampling edge.
- Console FIFO: con_valid_o = !empty and con_data_o = head byte. A pop happens on an edge with con_valid_o & con_ready_i.
  - Push and pop in the same cycle when full: both succeed, the count stays 4, and overflow is not set.
  - Push into an empty FIFO: no bypass; con_valid_o rises the next cycle.
  - Read and write pointers are 2-bit and wrap. The count is held in a 3-bit register covering 0..4.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and the data is valid after edge N until the next read edge.
- A write at edge N is visible to a read sampled at edge N+1.
- tohost_valid_o is high for exactly the cycle after the TOHOST write edge. Back-to-back writes give back-to-back pulses.
- Reset values, applied at the edge where reset_n=0:
  - DMEM_data_o, con_data_o, tohost_o, mtime and the shadow register = 0.
  - con_valid_o, tohost_valid_o and overflow = 0.
  - FIFO is empty with pointers at 0.
- RAM contents are not affected by reset.
- Reset asserted mid-operation flushes the FIFO, cancels any pending tohost pulse and discards any write or read sampled at that edge.

## Test plan
- RAM byte lanes: SW 0x11223344 to 0x100, then SB 0xAA with lanes 0100, then read 0x100 → 0x11AA3344. A read of 0x100 + 4*DEPTH_WORDS returns the same word (alias).
- Read-first and latency: in one cycle, read 0x200 (holding 0xDEAD0000) while SW 0xBEEF0000 to 0x200 → DMEM_data_o = 0xDEAD0000 one cycle later. The next read returns 0xBEEF0000. With the read de-asserted, DMEM_data_o holds.
- Console FIFO: with con_ready_i=0, push 'A','B','C','D','E' → status reads 0b110 and con_data_o='A'. Raise ready → 'A'..'D' drain in 4 cycles, then status reads 0b101. A write to 0x04 clears overflow.
- Full push+pop: fill the FIFO to 4, then push 'X' in the same cycle as a pop → count stays 4, no overflow, and 'X' emerges last.
- mtime: release reset and read MTIME_LO at edge 10 → 9. Force mtime to 0x0000_0000_FFFF_FFFF, read LO then HI → 0xFFFFFFFF followed by 0x00000000 (no tear).
- TOHOST: SW 0x1 to MMIO_BASE+0x10 → tohost_valid_o pulses for 1 cycle and tohost_o=1. An SH to the same address leaves it unchanged and produces no pulse. Asserting reset clears tohost_o to 0.
